// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
//
// Shares one single-write/single-read RAM between N_REQ requesters.  Two
// independent round-robin arbiters run side by side: one picks a writer for
// the RAM write port, the other picks a reader for the RAM read port, so up
// to one write and one read are accepted every cycle.  The ID of an accepted
// read is registered and used the next cycle to steer the RAM's registered
// read data back to the requester that issued it.
//
// Parameters
//   D_WIDTH  data width (must equal the RAM data width)
//   A_WIDTH  address width (must equal the RAM address width)
//   N_REQ    number of requesters, 2..16
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous reset, active low
//   req_valid       per-requester request valid
//   req_we          per-requester direction, 1 = write, 0 = read
//   req_addr        packed addresses, requester i at [i*A_WIDTH +: A_WIDTH]
//   req_wdata       packed write data, requester i at [i*D_WIDTH +: D_WIDTH]
//   req_ready       request accepted this cycle (combinational grant)
//   rsp_valid       one-hot read-data-valid, one cycle after a read accept
//   rsp_data        read data shared by all requesters, 0 when not valid
//   ram_write_en    RAM write enable
//   ram_write_addr  RAM write address (0 when no write granted)
//   ram_write_data  RAM write data (0 when no write granted)
//   ram_read_en     RAM read enable
//   ram_read_addr   RAM read address (0 when no read granted)
//   ram_read_data   RAM registered read data, valid the cycle after read_en
//
// Build option
//   RAM_ARB_RAW_FWD_EN  when defined, a read and a write granted in the same
//                       cycle to the same address return the written data.
//                       When undefined the read returns the old RAM contents
//                       and no forwarding registers exist.
// ---------------------------------------------------------------------------
module ram_arbiter #(
  parameter int D_WIDTH = 8,
  parameter int A_WIDTH = 4,
  parameter int N_REQ   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ-1:0]           req_we,
  input  logic [N_REQ*A_WIDTH-1:0]   req_addr,
  input  logic [N_REQ*D_WIDTH-1:0]   req_wdata,
  output logic [N_REQ-1:0]           req_ready,
  output logic [N_REQ-1:0]           rsp_valid,
  output logic [D_WIDTH-1:0]         rsp_data,
  output logic                       ram_write_en,
  output logic [A_WIDTH-1:0]         ram_write_addr,
  output logic [D_WIDTH-1:0]         ram_write_data,
  output logic                       ram_read_en,
  output logic [A_WIDTH-1:0]         ram_read_addr,
  input  logic [D_WIDTH-1:0]         ram_read_data
);

  localparam int              ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // Requester count and last ID in pointer-sized form for the modulo wrap.
  localparam logic [ID_W:0]   N_REQ_W = (ID_W + 1)'(N_REQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

  // Round-robin pick: scan ptr, ptr+1, ... wrapping at N_REQ (not at 2**ID_W,
  // so non-power-of-two requester counts never visit a phantom slot).
  // Result is {found, id}.
  function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] elig,
                                            input logic [ID_W-1:0]  ptr);
    logic [ID_W:0] res;
    logic [ID_W:0] idx;
    res = {(ID_W + 1){1'b0}};
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, ptr} + (ID_W + 1)'(k);
      idx = (idx >= N_REQ_W) ? (idx - N_REQ_W) : idx;
      if (!res[ID_W] && elig[idx[ID_W-1:0]]) begin
        res = {1'b1, idx[ID_W-1:0]};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Pointer advance: (g + 1) mod N_REQ.
  function automatic logic [ID_W-1:0] ptr_after(input logic [ID_W-1:0] g);
    return (g == LAST_ID) ? {ID_W{1'b0}} : (g + {{(ID_W-1){1'b0}}, 1'b1});
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] id);
    return {{(N_REQ-1){1'b0}}, 1'b1} << id;
  endfunction

  // Arbiter and read-tracking state.
  logic [ID_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ID_W-1:0] rd_ptr_q, rd_ptr_d;
  logic            rd_vld_q, rd_vld_d;
  logic [ID_W-1:0] rd_id_q,  rd_id_d;

  // Unpacked views of the request payload buses.
  logic [A_WIDTH-1:0] addr_arr_s  [N_REQ];
  logic [D_WIDTH-1:0] wdata_arr_s [N_REQ];

  logic [ID_W:0]   wr_pick_s, rd_pick_s;
  logic            wr_gnt_s,  rd_gnt_s;
  logic [ID_W-1:0] wr_id_s,   rd_id_s;

  // Split packed request buses into per-requester arrays.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      addr_arr_s[i]  = req_addr[i*A_WIDTH +: A_WIDTH];
      wdata_arr_s[i] = req_wdata[i*D_WIDTH +: D_WIDTH];
    end
  end

  // Grant selection for both ports; nothing is granted while reset is held.
  always_comb begin
    wr_pick_s = rr_pick(req_valid & req_we,  wr_ptr_q);
    rd_pick_s = rr_pick(req_valid & ~req_we, rd_ptr_q);
    wr_gnt_s  = rst & wr_pick_s[ID_W];
    rd_gnt_s  = rst & rd_pick_s[ID_W];
    wr_id_s   = wr_pick_s[ID_W-1:0];
    rd_id_s   = rd_pick_s[ID_W-1:0];
  end

  // Requester handshake and RAM port drive; idle ports present all zeros.
  always_comb begin
    req_ready      = {N_REQ{1'b0}};
    ram_write_en   = 1'b0;
    ram_write_addr = {A_WIDTH{1'b0}};
    ram_write_data = {D_WIDTH{1'b0}};
    ram_read_en    = 1'b0;
    ram_read_addr  = {A_WIDTH{1'b0}};
    if (wr_gnt_s) begin
      req_ready      = req_ready | onehot(wr_id_s);
      ram_write_en   = 1'b1;
      ram_write_addr = addr_arr_s[wr_id_s];
      ram_write_data = wdata_arr_s[wr_id_s];
    end else begin
      ram_write_en   = 1'b0;
    end
    if (rd_gnt_s) begin
      req_ready      = req_ready | onehot(rd_id_s);
      ram_read_en    = 1'b1;
      ram_read_addr  = addr_arr_s[rd_id_s];
    end else begin
      ram_read_en    = 1'b0;
    end
  end

  // Next-state: pointers advance past the winner and hold when idle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    rd_vld_d = rd_gnt_s;
    rd_id_d  = rd_id_q;
    if (wr_gnt_s) begin
      wr_ptr_d = ptr_after(wr_id_s);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_gnt_s) begin
      rd_ptr_d = ptr_after(rd_id_s);
      rd_id_d  = rd_id_s;
    end else begin
      rd_ptr_d = rd_ptr_q;
      rd_id_d  = rd_id_q;
    end
  end

  // Arbiter pointers and in-flight read tracking; reset drops any read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= {ID_W{1'b0}};
      rd_ptr_q <= {ID_W{1'b0}};
      rd_vld_q <= 1'b0;
      rd_id_q  <= {ID_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rd_vld_q <= rd_vld_d;
      rd_id_q  <= rd_id_d;
    end
  end

`ifdef RAM_ARB_RAW_FWD_EN
  logic               fwd_q,      fwd_d;
  logic [D_WIDTH-1:0] fwd_data_q, fwd_data_d;

  // Detect a same-cycle read and write to one address; the RAM itself would
  // return the old word, so the write data is captured for the response.
  always_comb begin
    fwd_d      = rd_gnt_s & wr_gnt_s & (ram_read_addr == ram_write_addr);
    fwd_data_d = ram_write_data;
  end

  // Forwarding flag and captured write data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwd_q      <= 1'b0;
      fwd_data_q <= {D_WIDTH{1'b0}};
    end else begin
      fwd_q      <= fwd_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  // Response steering with forwarded data taking priority over the RAM.
  always_comb begin
    rsp_valid = {N_REQ{1'b0}};
    rsp_data  = {D_WIDTH{1'b0}};
    if (rd_vld_q) begin
      rsp_valid = onehot(rd_id_q);
      rsp_data  = fwd_q ? fwd_data_q : ram_read_data;
    end else begin
      rsp_valid = {N_REQ{1'b0}};
      rsp_data  = {D_WIDTH{1'b0}};
    end
  end
`else
  // Response steering: RAM data goes to the requester whose read was accepted
  // last cycle; the shared data bus is held at zero otherwise.
  always_comb begin
    rsp_valid = {N_REQ{1'b0}};
    rsp_data  = {D_WIDTH{1'b0}};
    if (rd_vld_q) begin
      rsp_valid = onehot(rd_id_q);
      rsp_data  = ram_read_data;
    end else begin
      rsp_valid = {N_REQ{1'b0}};
      rsp_data  = {D_WIDTH{1'b0}};
    end
  end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_arbiter
//
// Drives ram_arbiter (4 requesters, 4-bit address, 8-bit data) with directed
// scenarios followed by randomized traffic.  A small behavioural RAM sits on
// the arbiter's RAM ports.  The expected handshake, RAM-port values and read
// responses come from a reference model: round-robin pointers kept as
// integers, a shadow memory array, and the response due next cycle.
// ---------------------------------------------------------------------------
module tb_ram_arbiter;
  localparam int N  = 4;
  localparam int AW = 4;
  localparam int DW = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_we;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic              ram_write_en;
  logic [AW-1:0]     ram_write_addr;
  logic [DW-1:0]     ram_write_data;
  logic              ram_read_en;
  logic [AW-1:0]     ram_read_addr;
  logic [DW-1:0]     ram_read_data = 8'h00;

  always #5 clk = ~clk;

  ram_arbiter #(.D_WIDTH(DW), .A_WIDTH(AW), .N_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .ram_write_en(ram_write_en), .ram_write_addr(ram_write_addr), .ram_write_data(ram_write_data),
    .ram_read_en(ram_read_en), .ram_read_addr(ram_read_addr), .ram_read_data(ram_read_data)
  );

  // Behavioural RAM: registered read returning pre-write contents.
  logic [DW-1:0] mem [16] = '{default: 8'h00};
  always @(posedge clk) begin
    if (ram_write_en) mem[ram_write_addr] <= ram_write_data;
    if (ram_read_en)  ram_read_data <= mem[ram_read_addr];
  end

  // Reference model state.
  int            wp, rp;
  logic [DW-1:0] ref_mem [16] = '{default: 8'h00};
  logic [N-1:0]  exp_rv;
  logic [DW-1:0] exp_rd;
  int            last_wg, last_rg;
  int            total, bad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic bit_of(input logic [N-1:0] v, input int i);
    logic [N-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  // First eligible requester at or after ptr, cyclically; -1 if none.
  function automatic int pick(input logic [N-1:0] elig, input int ptr);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (ptr + k) % N;
      if (bit_of(elig, i)) return i;
    end
    return -1;
  endfunction

  task automatic clr();
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [N-1:0] m;
    m = N'(1) << i;
    req_valid = req_valid | m;
    req_we    = we ? (req_we | m) : (req_we & ~m);
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  // One cycle: called at a falling edge with inputs applied; checks outputs
  // against the model, advances the model, returns at the next falling edge.
  task automatic step();
    int            wg, rg;
    logic [N-1:0]  xr, nv;
    logic          xwe, xre;
    logic [AW-1:0] xwa, xra;
    logic [DW-1:0] xwd, nd;
    #1;
    xr = '0; xwe = 1'b0; xre = 1'b0; xwa = '0; xra = '0; xwd = '0;
    if (rst) begin
      wg = pick(req_valid & req_we, wp);
      rg = pick(req_valid & ~req_we, rp);
    end else begin
      wg = -1;
      rg = -1;
    end
    if (wg >= 0) begin
      xr  = xr | (N'(1) << wg);
      xwe = 1'b1;
      xwa = req_addr[wg*AW +: AW];
      xwd = req_wdata[wg*DW +: DW];
    end
    if (rg >= 0) begin
      xr  = xr | (N'(1) << rg);
      xre = 1'b1;
      xra = req_addr[rg*AW +: AW];
    end
    check("req_ready", 32'(req_ready), 32'(xr));
    check("wr_en",     32'(ram_write_en), 32'(xwe));
    check("wr_addr",   32'(ram_write_addr), 32'(xwa));
    check("wr_data",   32'(ram_write_data), 32'(xwd));
    check("rd_en",     32'(ram_read_en), 32'(xre));
    check("rd_addr",   32'(ram_read_addr), 32'(xra));
    check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    check("rsp_data",  32'(rsp_data), 32'(exp_rd));
    nv = '0;
    nd = '0;
    if (rg >= 0) begin
      nv = N'(1) << rg;
      nd = ref_mem[xra];
`ifdef RAM_ARB_RAW_FWD_EN
      if (wg >= 0 && xwa == xra) nd = xwd;
`endif
    end
    if (wg >= 0) begin
      ref_mem[xwa] = xwd;
      wp = (wg + 1) % N;
    end
    if (rg >= 0) rp = (rg + 1) % N;
    if (!rst) begin
      wp = 0;
      rp = 0;
    end
    last_wg = wg;
    last_rg = rg;
    @(posedge clk);
    exp_rv = nv;
    exp_rd = nd;
    @(negedge clk);
  endtask

  initial begin
    logic [DW-1:0] hz_exp;
    total = 0; bad = 0; wp = 0; rp = 0;
    exp_rv = '0; exp_rd = '0; last_wg = -1; last_rg = -1;
    clr();
    #2 rst = 1'b0;

    // Reset held with every requester valid: nothing may be granted.
    for (int i = 0; i < N; i++) set_req(i, (i % 2) == 1, AW'(i), DW'(8'h10 + i));
    @(negedge clk);
    #1 check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    step();
    step();

    // Release; all four read continuously: grants 0,1,2,3,0.
    rst = 1'b1;
    clr();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(i), 8'h00);
    for (int c = 0; c < 5; c++) begin
      #1 check("rr_seq", 32'(req_ready), 32'(1) << (c % 4));
      step();
    end

    // All write: requester 0 wins first on the write arbiter too.
    clr();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(8 + 2 * i), DW'(8'h80 + i));
    #1 check("wr_first", 32'(req_ready), 32'h1);
    step();

    // Write addr 3 = A5 from req 1, then read it back from req 2.
    clr(); set_req(1, 1'b1, 4'd3, 8'hA5); step();
    clr(); set_req(2, 1'b0, 4'd3, 8'h00); step();
    #1 check("wrrd_valid", 32'(rsp_valid), 32'h4);
    check("wrrd_data", 32'(rsp_data), 32'hA5);
    clr(); step();

    // Concurrent write (req 0, addr 5) and read (req 3, addr 7 = 11).
    clr(); set_req(2, 1'b1, 4'd7, 8'h11); step();
    clr(); set_req(0, 1'b1, 4'd5, 8'h3C); set_req(3, 1'b0, 4'd7, 8'h00);
    #1 check("conc_ready", 32'(req_ready), 32'h9);
    step();
    #1 check("conc_valid", 32'(rsp_valid), 32'h8);
    check("conc_data", 32'(rsp_data), 32'h11);

    // Same-address hazard on addr 9 (holds 00).
`ifdef RAM_ARB_RAW_FWD_EN
    hz_exp = 8'hFF;
`else
    hz_exp = 8'h00;
`endif
    clr(); set_req(1, 1'b1, 4'd9, 8'hFF); set_req(2, 1'b0, 4'd9, 8'h00); step();
    #1 check("hazard_data", 32'(rsp_data), 32'(hz_exp));
    clr(); step();

    // Reset between read accept and the registering edge: response dropped.
    clr(); set_req(2, 1'b0, 4'd4, 8'h00);
    #1 check("mid_ready", 32'(req_ready), 32'h4);
    rst = 1'b0;
    #1 check("mid_rst_ready", 32'(req_ready), 32'h0);
    check("mid_rst_rd_en", 32'(ram_read_en), 32'h0);
    wp = 0; rp = 0; exp_rv = '0; exp_rd = '0;
    @(posedge clk);
    @(negedge clk);
    #1 check("mid_rsp_valid", 32'(rsp_valid), 32'h0);
    check("mid_rsp_data", 32'(rsp_data), 32'h0);
    rst = 1'b1;
    clr();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(i), 8'h00);
    #1 check("post_rst_rd", 32'(req_ready), 32'h1);
    step();
    clr();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(12 + i), DW'(8'hC0 + i));
    #1 check("post_rst_wr", 32'(req_ready), 32'h1);
    step();

    // Random traffic; requests hold payload until accepted.
    clr();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!bit_of(req_valid, i) && $urandom_range(0, 1) == 1)
          set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom_range(0, 255)));
      end
      step();
      if (last_wg >= 0) req_valid = req_valid & ~(N'(1) << last_wg);
      if (last_rg >= 0) req_valid = req_valid & ~(N'(1) << last_rg);
    end

    clr();
    step();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
